// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: SYNC_WORD then payload, both MSB-first, optional even parity (SERIAL_FRAME_TX_PARITY_EN).
// Latency: sync MSB on tx_out the cycle after accept; tx_ready high in IDLE and in the last clock of the frame.
// Backpressure: tx_valid is ignored while tx_ready is low; accept in the last clock chains frames back-to-back.
module serial_frame_tx #(
    parameter int         DATA_W       = 8,
    parameter logic [7:0] SYNC_WORD    = 8'hD5,
    parameter int         CLKS_PER_BIT = 4,
    parameter logic       IDLE_LEVEL   = 1'b0
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              frame_done
);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FW = 8 + DATA_W + PAR_W;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2((DATA_W > 8) ? DATA_W : 8);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] SYNC_TOP = BW'(7);
    localparam logic [BW-1:0] DATA_TOP = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
`ifdef SERIAL_FRAME_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam state_t LAST_ST = PARITY;
`else
    localparam state_t LAST_ST = DATA;
`endif

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [BW-1:0] idx, nxt_idx;
    logic [FW-1:0] sr, nxt_sr, ld_frame;
    logic          rdy_q;
    logic          accept;
    logic          bit_end;
    logic          nxt_final;

    // Whole frame is loaded at accept; the line always shows the shifter MSB.
`ifdef SERIAL_FRAME_TX_PARITY_EN
    assign ld_frame = {SYNC_WORD, tx_data, ^tx_data};
`else
    assign ld_frame = {SYNC_WORD, tx_data};
`endif

    assign tx_ready = rdy_q & ~reset;
    assign accept   = tx_valid & tx_ready;
    assign bit_end  = (cnt == CNT_LAST);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        nxt_sr    = sr;
        if (state != IDLE) begin
            if (bit_end) begin
                nxt_cnt = '0;
                nxt_sr  = {sr[FW-2:0], 1'b0};
            end else begin
                nxt_cnt = cnt + 1'b1;
            end
        end
        case (state)
            IDLE: ;
            SYNC: begin
                if (bit_end) begin
                    if (idx == '0) begin
                        nxt_state = DATA;
                        nxt_idx   = DATA_TOP;
                    end else begin
                        nxt_idx = idx - 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        nxt_state = PARITY;
`else
                        nxt_state = IDLE;
`endif
                    end else begin
                        nxt_idx = idx - 1'b1;
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) nxt_state = IDLE;
            end
`endif
            default: nxt_state = IDLE;
        endcase
        // Accept only happens in IDLE or the final clock, so it cleanly overrides the wind-down.
        if (accept) begin
            nxt_state = SYNC;
            nxt_idx   = SYNC_TOP;
            nxt_cnt   = '0;
            nxt_sr    = ld_frame;
        end
    end

    assign nxt_final = (nxt_state == LAST_ST) && (nxt_idx == '0) && (nxt_cnt == CNT_LAST);

    always_ff @(posedge clk50) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sr         <= '0;
            tx_out     <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            sr         <= nxt_sr;
            tx_out     <= (nxt_state == IDLE) ? IDLE_LEVEL : nxt_sr[FW-1];
            tx_busy    <= (nxt_state != IDLE);
            frame_done <= nxt_final;
            rdy_q      <= (nxt_state == IDLE) || nxt_final;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: default instance plus a 1-bit/1-clock instance, queue model of the line.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L0 = (16 + P) * 4;
    localparam int L1 = 9 + P;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data0 = 8'h00;
    logic       tx_valid0 = 1'b0;
    logic       tx_ready0, tx_out0, tx_busy0, frame_done0;
    logic [0:0] tx_data1 = 1'b0;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, tx_out1, tx_busy1, frame_done1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit q0[$];
    bit q1[$];
    bit prev_rst[2];
    int done_q[$];

    serial_frame_tx u_dut0 (
        .clk50(clk50), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .tx_out(tx_out0), .tx_busy(tx_busy0), .frame_done(frame_done0)
    );

    serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_dut1 (
        .clk50(clk50), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_out(tx_out1), .tx_busy(tx_busy1), .frame_done(frame_done1)
    );

    always #5 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected line contents are a queue of one bit per clock; empty queue means idle.
    task automatic model_step(input int u, input logic rst, input logic vld, input logic [31:0] dat,
                              input logic rdy, input logic out, input logic busy, input logic done);
        bit q[$];
        bit er, eb, ed, eo, par;
        int w, cpb;
        logic [7:0] sw;
        sw  = 8'hD5;
        w   = (u == 1) ? 1 : 8;
        cpb = (u == 1) ? 1 : 4;
        q   = (u == 1) ? q1 : q0;
        if (rst) begin
            chk("ready_in_reset", 32'(rdy), 32'd0);
            if (prev_rst[u]) begin
                chk("out_in_reset", 32'(out), 32'd0);
                chk("busy_in_reset", 32'(busy), 32'd0);
                chk("done_in_reset", 32'(done), 32'd0);
            end
            q.delete();
            prev_rst[u] = 1'b1;
        end else begin
            prev_rst[u] = 1'b0;
            eb = (q.size() != 0);
            eo = eb ? q[0] : 1'b0;
            ed = (q.size() == 1);
            er = !eb || ed;
            chk(u ? "m1_ready" : "m0_ready", 32'(rdy), 32'(er));
            chk(u ? "m1_out" : "m0_out", 32'(out), 32'(eo));
            chk(u ? "m1_busy" : "m0_busy", 32'(busy), 32'(eb));
            chk(u ? "m1_done" : "m0_done", 32'(done), 32'(ed));
            if (eb) void'(q.pop_front());
            if (vld && er) begin
                par = 1'b0;
                for (int i = 7; i >= 0; i--)
                    for (int k = 0; k < cpb; k++) q.push_back(sw[i]);
                for (int i = w - 1; i >= 0; i--) begin
                    par = par ^ dat[i];
                    for (int k = 0; k < cpb; k++) q.push_back(dat[i]);
                end
                if (P == 1)
                    for (int k = 0; k < cpb; k++) q.push_back(par);
            end
        end
        if (u == 1) q1 = q; else q0 = q;
    endtask

    always @(negedge clk50) begin
        model_step(0, reset, tx_valid0, {24'b0, tx_data0}, tx_ready0, tx_out0, tx_busy0, frame_done0);
        model_step(1, reset, tx_valid1, {31'b0, tx_data1}, tx_ready1, tx_out1, tx_busy1, frame_done1);
        if (frame_done0 === 1'b1) done_q.push_back(cyc);
    end

    // Directed frame with literal bit pattern (left-aligned in pat); called in the drive phase.
    task automatic run_frame(input int u, input logic [7:0] d, input logic [16:0] pat);
        int cpb, len;
        logic o, dn, r;
        cpb = (u == 1) ? 1 : 4;
        len = (u == 1) ? L1 : L0;
        if (u == 1) begin tx_valid1 = 1'b1; tx_data1 = d[0]; end
        else begin tx_valid0 = 1'b1; tx_data0 = d; end
        @(negedge clk50);
        r = (u == 1) ? tx_ready1 : tx_ready0;
        chk("lit_ready_idle", 32'(r), 32'd1);
        @(posedge clk50); #1;
        if (u == 1) begin tx_valid1 = 1'b0; tx_data1 = ~d[0]; end
        else begin tx_valid0 = 1'b0; tx_data0 = ~d; end
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk50);
            o  = (u == 1) ? tx_out1 : tx_out0;
            dn = (u == 1) ? frame_done1 : frame_done0;
            chk("lit_out", 32'(o), (c <= len) ? 32'(pat[16 - (c - 1) / cpb]) : 32'd0);
            chk("lit_done", 32'(dn), 32'(c == len));
            @(posedge clk50); #1;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk50);
        #1 reset = 1'b0;
        @(negedge clk50);
        chk("ready_after_reset", 32'(tx_ready0), 32'd1);
        chk("out_after_reset", 32'(tx_out0), 32'd0);
        @(posedge clk50); #1;

        run_frame(0, 8'hA3, {8'hD5, 8'hA3, 1'b0});
`ifdef SERIAL_FRAME_TX_PARITY_EN
        run_frame(0, 8'h07, {8'hD5, 8'h07, 1'b1});
`endif
        run_frame(1, 8'h01, {10'b1101010111, 7'b0});

        // Back-to-back: valid held, 00 then FF.
        done_q.delete();
        tx_valid0 = 1'b1;
        tx_data0  = 8'h00;
        n = 0;
        for (int k = 0; k < 400 && n < 2; k++) begin
            @(negedge clk50);
            if (tx_ready0) n++;
            @(posedge clk50); #1;
            if (n == 1) tx_data0 = 8'hFF;
        end
        tx_valid0 = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd2);
        repeat (L0 + 2) @(posedge clk50);
        #1;
        chk("b2b_done_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2) chk("b2b_done_gap", 32'(done_q[1] - done_q[0]), 32'(L0));

        // Reset pulse mid-payload, then a clean 5A frame.
        tx_valid0 = 1'b1;
        tx_data0  = 8'hC3;
        @(posedge clk50); #1;
        tx_valid0 = 1'b0;
        repeat ((8 + 2) * 4 + 1) @(posedge clk50);
        #1 reset = 1'b1;
        @(posedge clk50); #1 reset = 1'b0;
        @(negedge clk50);
        chk("rst_out_idle", 32'(tx_out0), 32'd0);
        chk("rst_busy", 32'(tx_busy0), 32'd0);
        chk("rst_ready", 32'(tx_ready0), 32'd1);
        @(posedge clk50); #1;
        run_frame(0, 8'h5A, {8'hD5, 8'h5A, 1'b0});

        // Random traffic with data churn while busy and rare resets.
        for (int k = 0; k < 4000; k++) begin
            tx_valid0 = ($urandom_range(0, 3) != 0);
            tx_data0  = 8'($urandom);
            tx_valid1 = ($urandom_range(0, 2) != 0);
            tx_data1  = 1'($urandom);
            reset     = ($urandom_range(0, 399) == 0);
            @(posedge clk50); #1;
        end
        reset = 1'b0;
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
        repeat (L0 + 4) @(posedge clk50);
        #1;
        chk("final_idle_out", 32'(tx_out0), 32'd0);
        chk("final_idle_busy", 32'(tx_busy0 | tx_busy1), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
